// File: rtl/lpddr2_port_arbiter.sv
// lpddr2_port_arbiter: round-robin sharing of one LPDDR2 Avalon-MM port between two single-beat requesters
module lpddr2_port_arbiter #(
   parameter int          AVL_ADDR_W = 27,
   parameter int          TIMEOUT    = 1024,
   parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
   input  logic                  iCLK,
   input  logic                  iRST_n,
   input  logic                  local_init_done,
   input  logic                  r0_req,
   input  logic                  r0_we,
   input  logic [31:0]           r0_addr,
   input  logic [31:0]           r0_wdata,
   output logic [31:0]           r0_rdata,
   output logic                  r0_ack,
   input  logic                  r1_req,
   input  logic                  r1_we,
   input  logic [31:0]           r1_addr,
   input  logic [31:0]           r1_wdata,
   output logic [31:0]           r1_rdata,
   output logic                  r1_ack,
   input  logic                  avl_waitrequest_n,
   output logic [AVL_ADDR_W-1:0] avl_address,
   output logic [31:0]           avl_writedata,
   output logic                  avl_read,
   output logic                  avl_write,
   output logic                  avl_burstbegin,
   input  logic                  avl_readdatavalid,
   input  logic [31:0]           avl_readdata,
   output logic                  timeout_err,
   output logic [3:0]            c_state
);
   typedef enum logic [3:0] {INIT = 4'd0, IDLE = 4'd1, ISSUE = 4'd2, RWAIT = 4'd3, ACK = 4'd4} state_t;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);
   state_t        state;
   logic [CW-1:0] cnt;
   logic          gnt, we, last_grant;
   logic          pick1, sel_we;
   logic [31:0]   sel_addr, sel_wdata, rd_word;
   logic          unused;
   // r1 wins when it is the only requester or when r0 had the last turn
   assign pick1     = r1_req & (~r0_req | ~last_grant);
   assign sel_we    = pick1 ? r1_we : r0_we;
   assign sel_addr  = pick1 ? r1_addr : r0_addr;
   assign sel_wdata = pick1 ? r1_wdata : r0_wdata;
   assign rd_word   = avl_readdatavalid ? avl_readdata : ERR_DATA;
   assign c_state   = state;
   assign unused    = ^{r0_addr, r1_addr};
   // arbitration FSM with all Avalon and requester outputs registered
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state          <= INIT;
         cnt            <= '0;
         gnt            <= 1'b0;
         we             <= 1'b0;
         last_grant     <= 1'b1;
         avl_address    <= '0;
         avl_writedata  <= '0;
         avl_read       <= 1'b0;
         avl_write      <= 1'b0;
         avl_burstbegin <= 1'b0;
         r0_rdata       <= '0;
         r1_rdata       <= '0;
         r0_ack         <= 1'b0;
         r1_ack         <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         r0_ack         <= 1'b0;
         r1_ack         <= 1'b0;
         avl_burstbegin <= 1'b0;
         case (state)
            INIT: if (local_init_done) state <= IDLE;
            IDLE: begin
               if (!local_init_done) state <= INIT;
               else if (r0_req | r1_req) begin
                  gnt            <= pick1;
                  last_grant     <= pick1;
                  we             <= sel_we;
                  avl_writedata  <= sel_wdata;
                  avl_address    <= sel_addr[AVL_ADDR_W+1:2];
                  avl_read       <= ~sel_we;
                  avl_write      <= sel_we;
                  avl_burstbegin <= 1'b1;
                  state          <= ISSUE;
               end
            end
            ISSUE: if (avl_waitrequest_n) begin
               avl_read  <= 1'b0;
               avl_write <= 1'b0;
               cnt       <= '0;
               r0_ack    <= we & ~gnt;
               r1_ack    <= we & gnt;
               state     <= we ? ACK : RWAIT;
            end
            RWAIT: begin
               if (avl_readdatavalid || cnt == CMAX) begin
                  if (gnt) r1_rdata <= rd_word;
                  else r0_rdata <= rd_word;
                  if (!avl_readdatavalid) timeout_err <= 1'b1;
                  r0_ack <= ~gnt;
                  r1_ack <= gnt;
                  state  <= ACK;
               end else cnt <= cnt + 1'b1;
            end
            ACK: state <= IDLE;
            default: state <= INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// tb_lpddr2_port_arbiter: scoreboard bench with a behavioural Avalon slave and two requester drivers
module tb_lpddr2_port_arbiter;
   typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} cmd_t;
   typedef struct {logic rd; logic [31:0] addr; logic [31:0] data;} exp_t;
   logic        clk = 0, rst_n, init_done;
   logic        req [2], we [2], ack [2];
   logic [31:0] addr [2], wdata [2], rdata [2];
   logic        waitn, valid, avl_read, avl_write, avl_burstbegin, timeout_err;
   logic [31:0] rdat, avl_writedata;
   logic [26:0] avl_address;
   logic [3:0]  c_state;
   cmd_t        cq [2][$];
   exp_t        sb [2][$];
   int          ack_log [$];
   logic [31:0] model [logic [26:0]];
   logic [31:0] mem [logic [26:0]];
   logic [31:0] exp_rd [2];
   int          checks = 0, errors = 0;
   int          waits = 0, rd_lat = 0;
   int          cyc = 0, last_cmd = 0, lat = 0, cmd_len = 0, done_len = 0;
   logic [26:0] seen_addr;
   logic        seen_we;
   logic [31:0] seen_wd;

   always #5 clk = ~clk;

   lpddr2_port_arbiter #(.AVL_ADDR_W(27), .TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .iCLK(clk), .iRST_n(rst_n), .local_init_done(init_done),
      .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]), .r0_rdata(rdata[0]), .r0_ack(ack[0]),
      .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]), .r1_rdata(rdata[1]), .r1_ack(ack[1]),
      .avl_waitrequest_n(waitn), .avl_address(avl_address), .avl_writedata(avl_writedata),
      .avl_read(avl_read), .avl_write(avl_write), .avl_burstbegin(avl_burstbegin),
      .avl_readdatavalid(valid), .avl_readdata(rdat), .timeout_err(timeout_err), .c_state(c_state));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic push(input int g, input logic w, input logic [31:0] a, input logic [31:0] d, input logic to);
      cmd_t c;
      exp_t e;
      c.we = w; c.addr = a; c.wdata = d;
      e.rd = !w; e.addr = a;
      if (w) begin
         model[a[28:2]] = d;
         e.data = d;
      end else e.data = to ? 32'hDEAD_BEEF : (model.exists(a[28:2]) ? model[a[28:2]] : 32'h0);
      cq[g].push_back(c);
      sb[g].push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while ((cq[0].size() + cq[1].size() + sb[0].size() + sb[1].size()) != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", n < 1000, 1);
      repeat (3) @(negedge clk);
   endtask

   // Avalon slave: programmable waitrequest stretch and read latency (0 = never returns)
   initial begin
      int wc, pend;
      logic [26:0] ra;
      wc = 0; pend = 0; ra = '0;
      waitn = 0; valid = 0; rdat = 0;
      forever begin
         @(negedge clk);
         valid = 0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               valid = 1;
               rdat = mem.exists(ra) ? mem[ra] : 32'h0;
            end
         end
         if (avl_read | avl_write) begin
            if (wc < waits) begin
               waitn = 0;
               wc++;
            end else begin
               waitn = 1;
               wc = 0;
               if (avl_write) mem[avl_address] = avl_writedata;
               else if (rd_lat > 0) begin
                  pend = rd_lat;
                  ra = avl_address;
               end
            end
         end else begin
            waitn = 0;
            wc = 0;
         end
      end
   end

   // requesters: hold req until ack, drop it, leave one idle cycle, then take the next queued command
   initial begin
      int st [2], n [2];
      cmd_t c;
      for (int g = 0; g < 2; g++) begin
         st[g] = 0; n[g] = 0; req[g] = 0; we[g] = 0; addr[g] = 0; wdata[g] = 0;
      end
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            if (st[g] == 0) begin
               if (cq[g].size() != 0) begin
                  c = cq[g].pop_front();
                  we[g] = c.we; addr[g] = c.addr; wdata[g] = c.wdata;
                  req[g] = 1; n[g] = 0; st[g] = 1;
               end
            end else if (st[g] == 1) begin
               n[g]++;
               if (!rst_n || ack[g] || n[g] >= 300) begin
                  if (rst_n && !ack[g]) chk("ack_wait", n[g], 0);
                  req[g] = 0;
                  st[g] = 2;
               end
            end else st[g] = 0;
         end
      end
   end

   // monitor: command framing checks and scoreboard comparison on every ack
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (avl_read | avl_write) begin
            chk("cmd_state", c_state, 2);
            chk("cmd_excl", avl_read & avl_write, 0);
            chk("bb_first", avl_burstbegin, cmd_len == 0);
            if (cmd_len == 0) begin
               seen_addr = avl_address; seen_we = avl_write; seen_wd = avl_writedata;
            end else chk("addr_hold", avl_address, seen_addr);
            cmd_len++;
            last_cmd = cyc;
         end else begin
            chk("bb_idle", avl_burstbegin, 0);
            if (cmd_len != 0) begin
               done_len = cmd_len;
               cmd_len = 0;
            end
         end
         for (int g = 0; g < 2; g++) if (ack[g]) begin
            chk("ack_one", ack[0] & ack[1], 0);
            chk("ack_exp", sb[g].size() != 0, 1);
            lat = cyc - last_cmd;
            ack_log.push_back(g);
            if (sb[g].size() != 0) begin
               e = sb[g].pop_front();
               chk("addr", seen_addr, e.addr[28:2]);
               chk("we", seen_we, !e.rd);
               if (e.rd) begin
                  chk("rdata", rdata[g], e.data);
                  exp_rd[g] = e.data;
               end else begin
                  chk("wdata", seen_wd, e.data);
                  chk("rd_keep", rdata[g], exp_rd[g]);
               end
               chk("rd_other", rdata[1-g], exp_rd[1-g]);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog at %0t", $time);
      $fatal(1);
   end

   initial begin
      int n;
      int order [4];
      order = '{0, 1, 0, 1};
      exp_rd = '{32'h0, 32'h0};
      rst_n = 1; init_done = 0;
      #1 rst_n = 0;
      repeat (3) @(negedge clk);
      chk("rst_state", c_state, 0);
      chk("rst_ack0", ack[0], 0);
      chk("rst_ack1", ack[1], 0);
      chk("rst_rd", avl_read, 0);
      chk("rst_wr", avl_write, 0);
      chk("rst_bb", avl_burstbegin, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_rdata0", rdata[0], 0);
      rst_n = 1;
      push(0, 1, 32'h0000_0010, 32'hCAFE_F00D, 0);
      repeat (20) @(negedge clk);
      chk("init_hold", c_state, 0);
      chk("init_nocmd", avl_read | avl_write, 0);
      init_done = 1;
      @(negedge clk);
      chk("idle", c_state, 1);
      @(negedge clk);
      chk("issue", c_state, 2);
      chk("wr_cmd", avl_write, 1);
      chk("wr_addr", avl_address, 4);
      chk("wr_bb", avl_burstbegin, 1);
      @(negedge clk);
      chk("wr_ack", ack[0], 1);
      drain();
      waits = 3; rd_lat = 5;
      push(1, 0, 32'h0000_0010, 32'h0, 0);
      drain();
      chk("rd_hold", done_len, 4);
      chk("rd_lat", lat, 6);
      waits = 0; rd_lat = 2;
      ack_log.delete();
      push(0, 1, 32'h0000_0100, 32'h0000_0001, 0);
      push(0, 0, 32'h0000_0010, 32'h0, 0);
      push(1, 1, 32'h0000_0200, 32'h0000_0002, 0);
      push(1, 0, 32'h0000_0100, 32'h0, 0);
      drain();
      chk("rr_count", ack_log.size(), 4);
      for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("rr_order", ack_log[i], order[i]);
      rd_lat = 0;
      push(0, 0, 32'h0000_0040, 32'h0, 1);
      drain();
      chk("to_lat", lat, 17);
      chk("to_err", timeout_err, 1);
      rd_lat = 3;
      push(0, 0, 32'h0000_0010, 32'h0, 0);
      drain();
      chk("to_sticky", timeout_err, 1);
      rd_lat = 8;
      push(1, 0, 32'h0000_0010, 32'h0, 0);
      n = 0;
      while (c_state != 3 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rwait_reached", c_state, 3);
      @(negedge clk);
      rst_n = 0;
      sb[1].delete();
      exp_rd = '{32'h0, 32'h0};
      #1;
      chk("ar_state", c_state, 0);
      chk("ar_ack", ack[1], 0);
      chk("ar_rd", avl_read, 0);
      chk("ar_rdata0", rdata[0], 0);
      chk("ar_rdata1", rdata[1], 0);
      chk("ar_terr", timeout_err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (12) @(negedge clk);
      chk("post_state", c_state, 1);
      chk("post_rdata1", rdata[1], 0);
      chk("post_terr", timeout_err, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
